// File: rtl/lms_pkg.sv
// Shared types and helpers for the sequential LMS adaptive filter.
// Saturation and leading-one helpers work on 64-bit values; callers size-cast the result.
package lms_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_ERR  = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SIGN = 2'b00;
  localparam logic [1:0] MODE_POW2 = 2'b01;

  // Accumulator must hold TAPS full products without overflow.
  function automatic int calc_accw(input int xw, input int ww, input int taps);
    return xw + ww + $clog2(taps);
  endfunction

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Index of the highest set bit; zero input returns 0.
  function automatic int lead_one(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lms_seq_filter_wupd.sv
// Combinational weight-update datapath for one tap; shared across taps by the UPD counter.
// Produces the saturated next weight for the selected update rule.
module lms_wupd
  import lms_pkg::*;
#(
  parameter int XW       = 8,
  parameter int DW       = 10,
  parameter int WW       = 10,
  parameter int MU_SHIFT = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [DW-1:0] e,
  input  logic        [1:0]    mode,
  input  logic signed [WW-1:0] w,
  output logic signed [WW-1:0] w_next
);

  logic signed [63:0] x64;
  logic signed [63:0] sx;
  logic signed [63:0] e_mag;
  logic signed [63:0] delta;
  logic signed [63:0] sum;
  logic               e_neg;
  logic               e_zero;
  int                 p;

  always_comb begin
    x64    = 64'(x);
    e_neg  = e[DW-1];
    e_zero = (e == '0);
    // Negating in 64 bits makes |most-negative e| come out as 2^(DW-1).
    e_mag  = e_neg ? -64'(e) : 64'(e);
    p      = lead_one(e_mag);
    sx     = e_neg ? -x64 : x64;
    delta  = '0;
    if (!e_zero) begin
      case (mode)
        MODE_SIGN: delta = e_neg ? -(x64 >>> MU_SHIFT) : (x64 >>> MU_SHIFT);
        MODE_POW2: delta = (sx <<< p) >>> MU_SHIFT;
        default:   delta = '0;
      endcase
    end
    sum    = 64'(w) + delta;
    w_next = WW'(sat_s(sum, WW));
  end

endmodule

// File: rtl/lms_seq_filter.sv
// Sequential LMS adaptive FIR: one shared multiplier, one tap per cycle for both the
// filter MAC and the weight update. One sample in flight at a time.
module lms_seq_filter
  import lms_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int XW       = 8,
  parameter int DW       = 10,
  parameter int WW       = 10,
  parameter int WFRAC    = 6,
  parameter int MU_SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] x_in,
  input  logic signed [DW-1:0] d_in,
  input  logic        [1:0]    mode,
  input  logic                 wclr,
  output logic                 out_valid,
  output logic signed [DW-1:0] y_out,
  output logic signed [DW-1:0] e_out,
  output state_t               state_dbg
);

  // Handshake: a sample is taken on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE without wclr; in_valid while busy is dropped.
  // out_valid is a single-cycle pulse in DONE, with y_out/e_out held until the next one.

  localparam int ACCW = calc_accw(XW, WW, TAPS);
  localparam int CW   = $clog2(TAPS);
  localparam int PW   = XW + WW;

  state_t                 state;
  state_t                 state_nx;
  logic        [CW-1:0]   cnt;
  logic                   last_tap;
  logic signed [XW-1:0]   x_dl  [TAPS];
  logic signed [WW-1:0]   w_mem [TAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   d_reg;
  logic signed [DW-1:0]   y_reg;
  logic signed [DW-1:0]   e_reg;
  logic        [1:0]      mode_reg;
  logic signed [PW-1:0]   prod;
  logic signed [DW-1:0]   y_new;
  logic signed [DW-1:0]   e_new;
  logic signed [WW-1:0]   w_next;

  assign state_dbg = state;
  assign last_tap  = (cnt == CW'(TAPS - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !wclr;
        if (in_valid && !wclr) state_nx = S_MAC;
      end
      S_MAC:   if (last_tap) state_nx = S_ERR;
      S_ERR:   state_nx = S_UPD;
      S_UPD:   if (last_tap) state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    prod  = PW'(w_mem[cnt]) * PW'(x_dl[cnt]);
    // Arithmetic shift floors toward minus infinity before saturation.
    y_new = DW'(sat_s(64'(acc) >>> WFRAC, DW));
    e_new = DW'(sat_s(64'(d_reg) - 64'(y_new), DW));
  end

  lms_wupd #(
    .XW       (XW),
    .DW       (DW),
    .WW       (WW),
    .MU_SHIFT (MU_SHIFT)
  ) u_wupd (
    .x      (x_dl[cnt]),
    .e      (e_reg),
    .mode   (mode_reg),
    .w      (w_mem[cnt]),
    .w_next (w_next)
  );

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      d_reg    <= '0;
      y_reg    <= '0;
      e_reg    <= '0;
      mode_reg <= '0;
      y_out    <= '0;
      e_out    <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_dl[k]  <= '0;
        w_mem[k] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (wclr) begin
            for (int k = 0; k < TAPS; k++) w_mem[k] <= '0;
          end else if (in_valid) begin
            acc      <= '0;
            d_reg    <= d_in;
            mode_reg <= mode;
            x_dl[0]  <= x_in;
            for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
          end
        end
        S_MAC: begin
          acc <= acc + ACCW'(prod);
          cnt <= last_tap ? '0 : cnt + CW'(1);
        end
        S_ERR: begin
          y_reg <= y_new;
          e_reg <= e_new;
        end
        S_UPD: begin
          w_mem[cnt] <= w_next;
          cnt        <= last_tap ? '0 : cnt + CW'(1);
          // Results become visible together with out_valid in DONE.
          if (last_tap) begin
            y_out <= y_reg;
            e_out <= e_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_seq_filter.sv
// Directed bench for lms_seq_filter (TAPS=8, XW=8, DW=10, WW=10, WFRAC=6, MU_SHIFT=4).
// Expected values are hand-derived from the LMS rules; a small model covers the frozen-weight run.
module tb_lms_seq_filter;
  import lms_pkg::*;

  localparam int TAPS = 8;
  localparam int XW   = 8;
  localparam int DW   = 10;
  localparam int WW   = 10;

  logic                 clk = 1'b0;
  logic                 r = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [XW-1:0] x_in = '0;
  logic signed [DW-1:0] d_in = '0;
  logic        [1:0]    mode = 2'b00;
  logic                 wclr = 1'b0;
  logic                 out_valid;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] e_out;
  state_t               state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  lms_seq_filter #(
    .TAPS(TAPS), .XW(XW), .DW(DW), .WW(WW), .WFRAC(6), .MU_SHIFT(4)
  ) dut (
    .clk       (clk),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .d_in      (d_in),
    .mode      (mode),
    .wclr      (wclr),
    .out_valid (out_valid),
    .y_out     (y_out),
    .e_out     (e_out),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    wclr     = 1'b0;
    r        = 1'b0;
    repeat (2) step();
    r = 1'b1;
    step();
  endtask

  // Scoreboard compare
  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_w(input int k, input int exp);
    check($sformatf("w%0d", k), dut.w_mem[k], exp);
  endtask

  // Driver: one sample; returns the edge count to out_valid and the results.
  task automatic send(input int x, input int d, input logic [1:0] m, output int lat,
                      output logic signed [DW-1:0] y, output logic signed [DW-1:0] e);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      step();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    x_in     = XW'(x);
    d_in     = DW'(d);
    mode     = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
    y = y_out;
    e = e_out;
    step();
  endtask

  int lat;
  logic signed [DW-1:0] y;
  logic signed [DW-1:0] e;
  int xl[TAPS];
  int y_m, e_m, xr, dr, out_cnt, acc_seen;
  logic [DW-1:0] exp_v;

  initial begin
    do_reset();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_e", e_out, 0);

    // Sign-error update from zero weights, latency and pulse width
    send(16, 8, 2'b00, lat, y, e);
    check("t2_latency", lat + 1, 18);
    check("t2_y", y, 0);
    check("t2_e", e, 8);
    check("t2_pulse_low", out_valid, 0);
    check("t2_ready_back", in_ready, 1);
    check_w(0, 1);
    for (int k = 1; k < TAPS; k++) check_w(k, 0);

    // Pow2-error update, positive and negative x
    do_reset();
    send(16, 8, 2'b01, lat, y, e);
    check("t3_e", e, 8);
    check_w(0, 8);
    do_reset();
    send(-16, 8, 2'b01, lat, y, e);
    check("t3n_y", y, 0);
    check("t3n_e", e, 8);
    check_w(0, -8);

    // Weight climbs and clamps at +511; y saturates and e drops to 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(127, 511, 2'b01, lat, y, e);
      check($sformatf("t4_y%0d", i), y, (i == 0) ? 0 : 511);
      check($sformatf("t4_e%0d", i), e, (i == 0) ? 511 : 0);
      check_w(0, 511);
      check_w(1, 0);
    end

    // Most-negative error drives the weight to -512, then e saturates positive
    do_reset();
    send(127, -512, 2'b01, lat, y, e);
    check("t4n_e", e, -512);
    check_w(0, -512);
    send(127, -512, 2'b01, lat, y, e);
    check("t4n_y", y, -512);
    check("t4n_e0", e, 0);
    check_w(0, -512);
    send(127, 511, 2'b10, lat, y, e);
    check("t4n_esat", e, 511);

    // Asynchronous reset in the middle of the update phase
    x_in     = 8'sd10;
    d_in     = '0;
    mode     = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (12) step();
    check("t1_in_upd", state_dbg, S_UPD);
    check("t1_y_before", y_out, -512);
    r = 1'b0;
    #1;
    check("t1_out_valid", out_valid, 0);
    check("t1_y", y_out, 0);
    check("t1_e", e_out, 0);
    check_w(0, 0);
    step();
    r = 1'b1;
    step();
    check("t1_in_ready", in_ready, 1);
    send(0, 0, 2'b00, lat, y, e);
    check("t1_y_zero_x", y, 0);

    // Build weights {62,-4,0..}, then frozen modes must leave them untouched
    do_reset();
    send(64, 16, 2'b01, lat, y, e);
    check("t5_e0", e, 16);
    check_w(0, 64);
    send(32, 0, 2'b00, lat, y, e);
    check("t5_y1", y, 32);
    check("t5_e1", e, -32);
    check_w(0, 62);
    check_w(1, -4);
    for (int k = 0; k < TAPS; k++) xl[k] = 0;
    xl[0] = 32;
    xl[1] = 64;
    for (int i = 0; i < 10; i++) begin
      xr = int'($urandom_range(0, 255)) - 128;
      dr = int'($urandom_range(0, 1023)) - 512;
      for (int k = TAPS - 1; k > 0; k--) xl[k] = xl[k-1];
      xl[0] = xr;
      y_m = (62 * xl[0] - 4 * xl[1]) >>> 6;
      e_m = dr - y_m;
      if (e_m > 511) e_m = 511;
      if (e_m < -512) e_m = -512;
      send(xr, dr, 2'($urandom_range(2, 3)), lat, y, e);
      check($sformatf("t5_y_r%0d", i), y, y_m);
      check($sformatf("t5_e_r%0d", i), e, e_m);
    end
    check_w(0, 62);
    check_w(1, -4);
    for (int k = 2; k < TAPS; k++) check_w(k, 0);

    // wclr in IDLE clears weights, blocks the accept for that cycle
    wclr     = 1'b1;
    in_valid = 1'b1;
    x_in     = 8'sd5;
    #1;
    check("t5_wclr_ready", in_ready, 0);
    step();
    wclr     = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_wclr_noaccept", state_dbg, S_IDLE);
    for (int k = 0; k < TAPS; k++) check_w(k, 0);

    // in_valid held for 100 cycles: accepts every 19 cycles, busy samples ignored
    do_reset();
    send(64, 16, 2'b01, lat, y, e);
    check_w(0, 64);
    exp_q.delete();
    out_cnt  = 0;
    acc_seen = 0;
    for (int i = 0; i < 100; i++) begin
      x_in     = XW'(i + 1);
      d_in     = '0;
      mode     = 2'b10;
      in_valid = 1'b1;
      if (i % 19 == 0) exp_q.push_back(DW'(i + 1));
      if (in_ready) acc_seen++;
      step();
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) check("t6_unexpected_out", out_valid, 0);
        else begin
          exp_v = exp_q.pop_front();
          check($sformatf("t6_y%0d", out_cnt), y_out, exp_v);
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && out_cnt < 6; i++) begin
      step();
      if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) check("t6_unexpected_out", out_valid, 0);
        else begin
          exp_v = exp_q.pop_front();
          check($sformatf("t6_y%0d", out_cnt), y_out, exp_v);
        end
      end
    end
    check("t6_accepts", acc_seen, 6);
    check("t6_outs", out_cnt, 6);
    check("t6_queue_empty", exp_q.size(), 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
